// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
package seven_seg_pkg;

  // Segment bus {dp,g..a} and anode selects are active-low.
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic       SEL_OFF = 1'b1;

  // Ceiling log2 for counter widths; never returns less than 1 so that a
  // modulo-1 or modulo-2 counter still gets a legal one-bit register.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < value) width++;
    return width;
  endfunction

  // Hex glyphs (0-9, A, b, C, d, E, F) as active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_segments(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-MODULUS counter emitting a pulse on its last count.
module tick_divider
  import seven_seg_pkg::*;
#(
  parameter int unsigned MODULUS = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned W = clog2(MODULUS);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == W'(MODULUS - 1));

  // Advance the count, wrapping to zero on the tick cycle.
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// N-digit common-anode scanner: frame snapshot, blink/dp masks, leading-zero
// blanking, PWM dimming and a one-cycle dark gap between digits.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUMBER_OF_DIGITS            = 4,
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned REFRESH_RATE_IN_HERTZ       = 500,
  parameter int unsigned BLINK_RATE_IN_HERTZ         = 2,
  parameter int unsigned BRIGHTNESS_BITS             = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [4*NUMBER_OF_DIGITS-1:0]   number,
  input  logic [NUMBER_OF_DIGITS-1:0]     dp_mask,
  input  logic [NUMBER_OF_DIGITS-1:0]     blink_mask,
  input  logic                            blank_leading_zeros,
  input  logic [BRIGHTNESS_BITS-1:0]      brightness,
  output logic [NUMBER_OF_DIGITS-1:0]     io_sel,
  output logic [7:0]                      io_seg,
  output logic                            frame_start
);

  localparam int unsigned N                 = NUMBER_OF_DIGITS;
  localparam int unsigned B                 = BRIGHTNESS_BITS;
  localparam int unsigned CYCLES_PER_DIGIT  = BOARD_CLOCK_FREQUENCY_IN_HZ / REFRESH_RATE_IN_HERTZ / N;
  localparam int unsigned BLINK_HALF_PERIOD = BOARD_CLOCK_FREQUENCY_IN_HZ / (2 * BLINK_RATE_IN_HERTZ);
  localparam int unsigned IDX_W             = clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N - 1);

  if (N < 1) begin : g_bad_digits
    $error("NUMBER_OF_DIGITS must be at least 1");
  end
  if (CYCLES_PER_DIGIT < (32'd1 << B)) begin : g_bad_slot
    $error("CYCLES_PER_DIGIT must be at least 2**BRIGHTNESS_BITS");
  end

  logic slot_tick, blink_tick;

  tick_divider #(.MODULUS(CYCLES_PER_DIGIT)) u_slot_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (slot_tick)
  );

  tick_divider #(.MODULUS(BLINK_HALF_PERIOD)) u_blink_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (blink_tick)
  );

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4*N-1:0]   snap_num_q, snap_num_d;
  logic [N-1:0]     snap_dp_q, snap_dp_d;
  logic [N-1:0]     snap_blink_q, snap_blink_d;
  logic             snap_blz_q, snap_blz_d;
  logic [B-1:0]     snap_bright_q, snap_bright_d;
  logic [B-1:0]     pwm_q, pwm_d;
  logic             phase_q, phase_d;
  logic [N-1:0]     sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;
  logic             fs_q, fs_d;
  logic             load;

  // Next digit index, frame snapshot and free-running PWM/blink state.
  always_comb begin
    idx_d = idx_q;
    if (slot_tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    load          = slot_tick && (idx_d == '0);
    snap_num_d    = load ? number              : snap_num_q;
    snap_dp_d     = load ? dp_mask             : snap_dp_q;
    snap_blink_d  = load ? blink_mask          : snap_blink_q;
    snap_blz_d    = load ? blank_leading_zeros : snap_blz_q;
    snap_bright_d = load ? brightness          : snap_bright_q;
    pwm_d         = pwm_q + B'(1);
    phase_d       = phase_q ^ blink_tick;
  end

  logic [N-1:0] lz_blank;
  logic         zero_run;
  logic [3:0]   digit;
  logic         dp_bit;
  logic         blank;
  logic         pwm_on;

  // Output decode is taken from next-state values so the registered pins
  // line up with the index/slot they describe (gap on the slot-0 cycle).
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      zero_run    = zero_run && (snap_num_d[4*i +: 4] == 4'h0);
      lz_blank[i] = snap_blz_d && zero_run && (i != 0);
    end
    digit  = 4'h0;
    dp_bit = 1'b0;
    blank  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (idx_d == IDX_W'(i)) begin
        digit  = snap_num_d[4*i +: 4];
        dp_bit = snap_dp_d[i];
        blank  = lz_blank[i] || (phase_d && snap_blink_d[i]);
      end
    end
    pwm_on = (&snap_bright_d) || (pwm_d < snap_bright_d);
    seg_d  = blank ? SEG_OFF : {~dp_bit, hex_to_segments(digit)};
    sel_d  = {N{SEL_OFF}};
    for (int i = 0; i < int'(N); i++) begin
      if ((idx_d == IDX_W'(i)) && !slot_tick && !blank && pwm_on) sel_d[i] = 1'b0;
    end
    fs_d = load;
  end

  // State and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= LAST_IDX;
      snap_num_q    <= '0;
      snap_dp_q     <= '0;
      snap_blink_q  <= '0;
      snap_blz_q    <= 1'b0;
      snap_bright_q <= '0;
      pwm_q         <= '0;
      phase_q       <= 1'b0;
      sel_q         <= {N{SEL_OFF}};
      seg_q         <= SEG_OFF;
      fs_q          <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      snap_num_q    <= snap_num_d;
      snap_dp_q     <= snap_dp_d;
      snap_blink_q  <= snap_blink_d;
      snap_blz_q    <= snap_blz_d;
      snap_bright_q <= snap_bright_d;
      pwm_q         <= pwm_d;
      phase_q       <= phase_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
      fs_q          <= fs_d;
    end
  end

  assign io_sel      = sel_q;
  assign io_seg      = seg_q;
  assign frame_start = fs_q;

endmodule
